// File: rtl/snake_engine.sv
// snake_engine: snake game logic driving the grid register's read/write port.
//   Keeps the body in a circular coordinate buffer, looks ahead at the next
//   head cell through the combinational read port, then erases the tail,
//   draws the head and places snacks through the registered write port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   game_start        level, leaves IDLE
//   game_restart      level, re-initialises from DELAY (any state but IDLE)
//   move_tick         one-cycle pulse, advances the snake one cell in RUN
//   dir               00 up, 01 right, 10 down, 11 left
//   rect_read_in      {x[15:0], y[15:0]} grid read address (registered)
//   rect_read_out     cell code at rect_read_in, same cycle
//   rect_write        {x[15:0], y[15:0], code[3:0]}, parked at {0,0,NULL}
//   game_over, score, snake_len  status (registered)
// Optional: define SNAKE_TAIL_CHASE_EN to let the head move into the cell the
//   tail vacates on the same move.
module snake_engine #(
  parameter int         MAX_LEN     = 64,
  parameter int         START_DELAY = 4,
  parameter int         SEEK_TRIES  = 255,
  parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_start,
  input  logic        game_restart,
  input  logic        move_tick,
  input  logic [1:0]  dir,
  output logic [31:0] rect_read_in,
  input  logic [3:0]  rect_read_out,
  output logic [35:0] rect_write,
  output logic        game_over,
  output logic [15:0] score,
  output logic [15:0] snake_len
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int TW = $clog2(SEEK_TRIES + 1);
  localparam logic [3:0]  C_NULL = 4'd0, C_SNAKE = 4'd1, C_SNACK = 4'd4;
  localparam logic [1:0]  D_UP = 2'd0, D_RIGHT = 2'd1, D_DOWN = 2'd2;
  localparam logic [35:0] PARK = 36'd0;

  typedef enum logic [3:0] {
    IDLE, DELAY, DRAW, RUN, LOOKUP, EVAL, CLEAR_TAIL, WRITE_HEAD, SEEK, PLACE, GAME_OVER
  } state_t;

  // x needs 6 bits: the right wall sits at x=32 and must be addressable.
  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } cell_t;

  function automatic logic [31:0] rd_word(cell_t c);
    return {10'd0, c.x, 11'd0, c.y};
  endfunction

  function automatic logic [35:0] wr_word(cell_t c, logic [3:0] f);
    return {10'd0, c.x, 11'd0, c.y, f};
  endfunction

  function automatic logic [9:0] lfsr_step(logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};  // x^10 + x^7 + 1
  endfunction

  function automatic cell_t lfsr_cand(logic [9:0] v);
    cell_t c;
    c.x = {1'b0, v[4:0]} + 6'd1;
    c.y = v[9:5];
    return c;
  endfunction

  function automatic cell_t step_cell(cell_t c, logic [1:0] d);
    cell_t n;
    n = c;
    case (d)
      D_UP:    n.y = c.y - 5'd1;
      D_RIGHT: n.x = c.x + 6'd1;
      D_DOWN:  n.y = c.y + 5'd1;
      default: n.x = c.x - 6'd1;
    endcase
    return n;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [1:0]      draw_q, draw_d, hdir_q, hdir_d, new_dir;
  cell_t           nh_q, nh_d, cand_q, cand_d;
  logic            grow_q, grow_d, ate_q, ate_d, over_q, over_d, chase_ok;
  logic [TW-1:0]   tries_q, tries_d;
  logic [9:0]      lfsr_q, lfsr_d;
  logic [31:0]     rd_q, rd_d;
  logic [35:0]     wr_q, wr_d;
  logic [15:0]     score_q, score_d, len_q, len_d;
  logic [PW-1:0]   tail_q, tail_d, head_q, head_d;
  logic            body_load;
  cell_t           body [MAX_LEN];

  assign new_dir = (dir == (hdir_q ^ 2'b10)) ? hdir_q : dir;  // no 180 turns

`ifdef SNAKE_TAIL_CHASE_EN
  // The tail is erased before the head is drawn, so entering it is safe.
  assign chase_ok = (rect_read_out == C_SNAKE) && (nh_q == body[tail_q]);
`else
  assign chase_ok = 1'b0;
`endif

  always_comb begin
    state_d = state_q; dly_d = dly_q; draw_d = draw_q; hdir_d = hdir_q;
    nh_d = nh_q; cand_d = cand_q; grow_d = grow_q; ate_d = ate_q;
    over_d = over_q; tries_d = tries_q; rd_d = rd_q; wr_d = PARK;
    score_d = score_q; len_d = len_q; tail_d = tail_q; head_d = head_q;
    lfsr_d = lfsr_step(lfsr_q);
    unique case (state_q)
      IDLE:    if (game_start) state_d = DELAY;
      DELAY:
        if (dly_q == DW'(START_DELAY - 1)) begin
          state_d = DRAW; draw_d = 2'd0;
          wr_d = wr_word('{x: 6'd14, y: 5'd12}, C_SNAKE);
        end else dly_d = dly_q + DW'(1);
      DRAW:
        if (draw_q == 2'd2) state_d = RUN;
        else begin
          draw_d = draw_q + 2'd1;
          wr_d = wr_word('{x: 6'd15 + {4'd0, draw_q}, y: 5'd12}, C_SNAKE);
        end
      RUN:
        if (move_tick) begin
          hdir_d = new_dir;
          nh_d = step_cell(body[head_q], new_dir);
          rd_d = rd_word(nh_d);
          state_d = LOOKUP;
        end
      LOOKUP:  state_d = EVAL;
      EVAL: begin
        ate_d = 1'b0; grow_d = 1'b0;
        if (rect_read_out == C_SNACK) begin
          ate_d = 1'b1; score_d = score_q + 16'd1;
          grow_d = (len_q < 16'(MAX_LEN));
        end
        if ((rect_read_out == C_SNACK && len_q < 16'(MAX_LEN))) begin
          state_d = WRITE_HEAD; wr_d = wr_word(nh_q, C_SNAKE);
        end else if (rect_read_out == C_SNACK || rect_read_out == C_NULL || chase_ok) begin
          state_d = CLEAR_TAIL; wr_d = wr_word(body[tail_q], C_NULL);
        end else begin
          state_d = GAME_OVER; over_d = 1'b1;
        end
      end
      CLEAR_TAIL: begin
        tail_d = tail_q + PW'(1);
        wr_d = wr_word(nh_q, C_SNAKE);
        state_d = WRITE_HEAD;
      end
      WRITE_HEAD: begin
        head_d = head_q + PW'(1);
        if (grow_q) len_d = len_q + 16'd1;
        // A snack eaten at full length still needs a replacement.
        if (ate_q) begin
          state_d = SEEK; tries_d = '0;
          cand_d = lfsr_cand(lfsr_q); rd_d = rd_word(cand_d);
        end else state_d = RUN;
      end
      SEEK:
        if (cand_q.y > 5'd23 || rect_read_out != C_NULL) begin
          lfsr_d = lfsr_step(lfsr_step(lfsr_q));
          if (tries_q == TW'(SEEK_TRIES - 1)) state_d = RUN;
          else begin
            tries_d = tries_q + TW'(1);
            cand_d = lfsr_cand(lfsr_d); rd_d = rd_word(cand_d);
          end
        end else begin
          state_d = PLACE; wr_d = wr_word(cand_q, C_SNACK);
        end
      PLACE:     state_d = RUN;
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase
    if (game_restart && state_q != IDLE) begin
      state_d = DELAY; wr_d = PARK;
    end
    // Full game re-init on every entry into DELAY.
    if (state_d == DELAY && state_q != DELAY || (game_restart && state_q != IDLE)) begin
      dly_d = '0; over_d = 1'b0; score_d = '0; len_d = 16'd3;
      tail_d = PW'(0); head_d = PW'(2); hdir_d = D_RIGHT;
    end
  end

  assign body_load = (state_d == DELAY);

  always_ff @(posedge clk) begin
    if (body_load) begin
      body[PW'(0)] <= '{x: 6'd14, y: 5'd12};
      body[PW'(1)] <= '{x: 6'd15, y: 5'd12};
      body[PW'(2)] <= '{x: 6'd16, y: 5'd12};
    end else if (state_q == WRITE_HEAD) begin
      body[head_q + PW'(1)] <= nh_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; dly_q <= '0; draw_q <= '0; hdir_q <= D_RIGHT;
      nh_q <= '0; cand_q <= '0; grow_q <= 1'b0; ate_q <= 1'b0;
      over_q <= 1'b0; tries_q <= '0; lfsr_q <= LFSR_SEED;
      rd_q <= '0; wr_q <= PARK; score_q <= '0; len_q <= '0;
      tail_q <= '0; head_q <= '0;
    end else begin
      state_q <= state_d; dly_q <= dly_d; draw_q <= draw_d; hdir_q <= hdir_d;
      nh_q <= nh_d; cand_q <= cand_d; grow_q <= grow_d; ate_q <= ate_d;
      over_q <= over_d; tries_q <= tries_d; lfsr_q <= lfsr_d;
      rd_q <= rd_d; wr_q <= wr_d; score_q <= score_d; len_q <= len_d;
      tail_q <= tail_d; head_q <= head_d;
    end
  end

  assign rect_read_in = rd_q;
  assign rect_write   = wr_q;
  assign game_over    = over_q;
  assign score        = score_q;
  assign snake_len    = len_q;
endmodule
